// File: rtl/random_sampler_pkg.sv
// Shared types and defaults for the random_sampler block.
package random_sampler_pkg;

    localparam int DEFAULT_WIDTH = 9;

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        WATCH = 2'd1,
        CAND  = 2'd2
    } state_t;

endpackage

// File: rtl/random_sampler_fifo.sv
// Synchronous first-word fall-through FIFO; caller must not push when full
// unless a pop happens in the same cycle.
module random_sampler_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;

    assign head  = mem[rd_ptr];
    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);
    assign count = cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // On full push+pop, wr_ptr equals rd_ptr: the popped slot is reused.
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/random_sampler.sv
// Captures each change of rnd_in as a range-qualified token and buffers it for
// a valid/ready consumer. Optional macro NO_REPEAT_EN drops repeats of the last push.
module random_sampler
    import random_sampler_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         rnd_in,
    input  logic [WIDTH-1:0]         limit,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] prev_in;
    logic [WIDTH-1:0] cand;
    logic             cand_ok;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push;
    logic             drop_full;

    always_comb begin
        state_next = state;
        case (state)
            PRIME:   state_next = WATCH;
            WATCH:   if (enable && rnd_in != prev_in) state_next = CAND;
            CAND:    state_next = WATCH;
            default: state_next = PRIME;
        endcase
    end

`ifdef NO_REPEAT_EN
    logic [WIDTH-1:0] last_pushed;
    logic             last_valid;
    logic             repeat_hit;

    assign repeat_hit = last_valid && (cand == last_pushed);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_pushed <= '0;
            last_valid  <= 1'b0;
        end else if (push) begin
            last_pushed <= cand;
            last_valid  <= 1'b1;
        end
    end
`else
    logic repeat_hit;
    assign repeat_hit = 1'b0;
`endif

    always_comb begin
        cand_ok   = (state == CAND) && !((limit != '0) && (cand >= limit)) && !repeat_hit;
        pop       = out_valid && out_ready;
        push      = cand_ok && (!fifo_full || pop);
        drop_full = cand_ok && fifo_full && !pop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= PRIME;
            prev_in  <= '0;
            cand     <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            // Holding prev_in during CAND lets WATCH catch a change that arrived meanwhile.
            if (state != CAND) begin
                prev_in <= rnd_in;
            end
            if (state == WATCH && enable && rnd_in != prev_in) begin
                cand <= rnd_in;
            end
            if (clr_ovf) begin
                overflow <= 1'b0;
            end else if (drop_full) begin
                overflow <= 1'b1;
            end
        end
    end

    random_sampler_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (cand),
        .pop       (pop),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_random_sampler.sv
// Directed self-checking bench for random_sampler (WIDTH=9, DEPTH=4).
module tb_random_sampler;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [8:0] rnd_in;
    logic [8:0] limit;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_data;
    logic [2:0] count;
    logic       overflow;
    logic       clr_ovf;

    int total = 0;
    int bad   = 0;

    random_sampler #(
        .WIDTH (9),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .rnd_in    (rnd_in),
        .limit     (limit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rnd_in change takes two edges: capture, then qualify/push.
    task automatic step_val(input logic [8:0] v);
        rnd_in = v;
        tick(2);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; rnd_in = 9'd7; limit = '0;
        out_ready = 1'b0; clr_ovf = 1'b0;
        tick(2);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", out_data, 0);

        reset = 1'b0;
        tick(20);
        chk("hold_valid", out_valid, 0);
        chk("hold_count", count, 0);

        rnd_in = 9'd12;
        tick(1);
        chk("lat_valid_e1", out_valid, 0);
        tick(1);
        chk("lat_valid_e2", out_valid, 1);
        chk("lat_data", out_data, 12);
        chk("lat_count", count, 1);
        out_ready = 1'b1; tick(1); out_ready = 1'b0;
        chk("drain1_count", count, 0);

        limit = 9'd100;
        step_val(9'd50);
        step_val(9'd150);
        step_val(9'd99);
        step_val(9'd100);
        chk("rng_count", count, 2);
        chk("rng_ovf", overflow, 0);
        chk("rng_head0", out_data, 50);
        out_ready = 1'b1; tick(1);
        chk("rng_head1", out_data, 99);
        tick(1); out_ready = 1'b0;
        chk("rng_empty", count, 0);

        limit = '0;
        for (int v = 1; v <= 5; v++) step_val(9'(v));
        chk("full_count", count, 4);
        chk("full_head", out_data, 1);
        chk("full_ovf", overflow, 1);
        clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
        chk("clr_ovf", overflow, 0);

        // Full drop and clear in the same cycle: clear wins.
        rnd_in = 9'd6; tick(1);
        clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
        chk("clr_prio", overflow, 0);

        rnd_in = 9'd9; tick(1);
        out_ready = 1'b1; tick(1); out_ready = 1'b0;
        chk("fpp_count", count, 4);
        chk("fpp_ovf", overflow, 0);
        chk("fpp_head", out_data, 2);
        out_ready = 1'b1;
        chk("dr_a", out_data, 2); tick(1);
        chk("dr_b", out_data, 3); tick(1);
        chk("dr_c", out_data, 4); tick(1);
        chk("dr_d", out_data, 9); tick(1);
        out_ready = 1'b0;
        chk("dr_empty", out_valid, 0);
        out_ready = 1'b1; tick(1); out_ready = 1'b0;
        chk("pop_empty_ignored", count, 0);

        enable = 1'b0;
        step_val(9'd20);
        chk("dis_count", count, 0);
        enable = 1'b1;
        tick(2);
        chk("reen_no_capture", count, 0);

        limit = 9'd10;
        step_val(9'd3);
        step_val(9'd15);
        step_val(9'd3);
        chk("rep_head", out_data, 3);
        chk("rep_ovf", overflow, 0);
`ifdef NO_REPEAT_EN
        chk("rep_count", count, 1);
`else
        chk("rep_count", count, 2);
        out_ready = 1'b1; tick(1); out_ready = 1'b0;
        chk("rep_second", out_data, 3);
`endif

        limit = '0;
        step_val(9'd40);
        rnd_in = 9'd41; tick(1);
        reset = 1'b1; tick(1); reset = 1'b0;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_valid", out_valid, 0);
        tick(3);
        chk("mid_rst_cand_gone", count, 0);
        step_val(9'd42);
        chk("post_rst_push", out_data, 42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
